// File: rtl/ternary_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ternary_seq_ctrl
// Purpose  : Phase controller for the ternary matrix-vector engine. Accepts
//            host commands, runs a gap-free weight-load burst into the loader,
//            then sequences input capture, compute and result drain per RUN.
// Revision : 1.0 - initial release
// ============================================================================
module ternary_seq_ctrl #(
  parameter  int MAX_IN_LEN  = 16,
  parameter  int MAX_OUT_LEN = 8,
  localparam int OUT_W   = $clog2(MAX_OUT_LEN),
  localparam int IN_W    = $clog2(MAX_IN_LEN),
  localparam int PARAM_W = IN_W + OUT_W,
  localparam int BEAT_W  = $clog2(2 * MAX_OUT_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [PARAM_W-1:0] cmd_param,
  output logic               cmd_ready,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               load_ena,
  output logic [PARAM_W-1:0] load_param,
  input  logic               load_done,
  output logic               mac_start,
  input  logic               mac_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_sel,
  output logic               weights_valid,
  output logic               busy,
  output logic [1:0]         err
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SETTLE   = 3'd2,
    S_RUN_IN   = 3'd3,
    S_RUN_COMP = 3'd4,
    S_DRAIN    = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [BEAT_W-1:0]  beat, beat_nx;
  logic               load_ena_nx;
  logic [PARAM_W-1:0] load_param_nx;
  logic               mac_start_nx;
  logic               out_valid_nx;
  logic [OUT_W-1:0]   out_sel_nx;
  logic               weights_valid_nx;
  logic [1:0]         err_nx;

  logic               abort;
  logic [BEAT_W-1:0]  last_beat;

  assign abort     = cmd_valid && (cmd_op == OP_ABORT);
  // Burst is two beats (MSB, LSB) per output column.
  assign last_beat = {load_param[OUT_W-1:0], 1'b1};

  // Handshake strobes decode from registered state. The burst and the vector
  // capture are both entered one cycle after data_valid is seen, so the word
  // is consumed in the same cycle load_ena / mac_start are high.
  assign cmd_ready  = (state == S_IDLE);
  assign data_ready = ((state == S_LOAD) && load_ena) ||
                      ((state == S_RUN_IN) && mac_start);

  // Register all state and registered outputs; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      beat          <= '0;
      load_ena      <= 1'b0;
      load_param    <= '0;
      mac_start     <= 1'b0;
      out_valid     <= 1'b0;
      out_sel       <= '0;
      weights_valid <= 1'b0;
      busy          <= 1'b0;
      err           <= 2'b00;
    end else begin
      state         <= state_nx;
      beat          <= beat_nx;
      load_ena      <= load_ena_nx;
      load_param    <= load_param_nx;
      mac_start     <= mac_start_nx;
      out_valid     <= out_valid_nx;
      out_sel       <= out_sel_nx;
      weights_valid <= weights_valid_nx;
      busy          <= (state_nx != S_IDLE);
      err           <= err_nx;
    end
  end

  // Next-state and next-output logic; ABORT overrides everything at the end.
  always_comb begin
    state_nx         = state;
    beat_nx          = beat;
    load_ena_nx      = load_ena;
    load_param_nx    = load_param;
    mac_start_nx     = 1'b0;
    out_valid_nx     = out_valid;
    out_sel_nx       = out_sel;
    weights_valid_nx = weights_valid;
    err_nx           = err;

    case (state)
      S_IDLE: begin
        if (cmd_valid && (cmd_op == OP_LOAD)) begin
          err_nx           = 2'b00;
          load_param_nx    = cmd_param;
          weights_valid_nx = 1'b0;
          beat_nx          = '0;
          load_ena_nx      = 1'b0;
          state_nx         = S_LOAD;
        end else if (cmd_valid && (cmd_op == OP_RUN)) begin
          load_param_nx = cmd_param;
          if (weights_valid) begin
            err_nx   = 2'b00;
            state_nx = S_RUN_IN;
          end else begin
            err_nx = 2'b10;
          end
        end
      end

      S_LOAD: begin
        if (!load_ena) begin
          if (data_valid) begin
            load_ena_nx = 1'b1;
            beat_nx     = '0;
          end
        end else if ((beat != '0) && !data_valid) begin
          // Underrun: the loader cannot tolerate a gap mid-burst.
          err_nx      = err | 2'b01;
          load_ena_nx = 1'b0;
          state_nx    = S_IDLE;
        end else if (beat == last_beat) begin
          load_ena_nx = 1'b0;
          if (load_done) begin
            state_nx = S_SETTLE;
          end else begin
            err_nx   = err | 2'b01;
            state_nx = S_IDLE;
          end
        end else begin
          beat_nx = beat + BEAT_W'(1);
        end
      end

      S_SETTLE: begin
        weights_valid_nx = 1'b1;
        state_nx         = S_IDLE;
      end

      S_RUN_IN: begin
        if (mac_start) begin
          state_nx = S_RUN_COMP;
        end else if (data_valid) begin
          mac_start_nx = 1'b1;
        end
      end

      S_RUN_COMP: begin
        if (mac_done) begin
          out_valid_nx = 1'b1;
          out_sel_nx   = '0;
          state_nx     = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (out_ready) begin
          if (out_sel == load_param[OUT_W-1:0]) begin
            out_valid_nx = 1'b0;
            out_sel_nx   = '0;
            state_nx     = S_IDLE;
          end else begin
            out_sel_nx = out_sel + OUT_W'(1);
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_nx     = S_IDLE;
      beat_nx      = '0;
      load_ena_nx  = 1'b0;
      mac_start_nx = 1'b0;
      out_valid_nx = 1'b0;
      out_sel_nx   = '0;
      err_nx       = err;
      // A partial or unsettled weight set is never usable.
      weights_valid_nx = ((state == S_LOAD) || (state == S_SETTLE)) ? 1'b0 : weights_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ternary_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ternary_seq_ctrl
// Purpose  : Self-checking bench for ternary_seq_ctrl: directed scenarios plus
//            randomized LOAD/RUN transactions against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [6:0] cmd_param = 7'd0;
  logic       cmd_ready;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       load_ena;
  logic [6:0] load_param;
  logic       load_done = 1'b0;
  logic       mac_start;
  logic       mac_done = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_sel;
  logic       weights_valid;
  logic       busy;
  logic [1:0] err;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state: does a usable weight set exist, sticky err.
  bit         m_wv  = 1'b0;
  logic [1:0] m_err = 2'b00;

  ternary_seq_ctrl #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_param(cmd_param), .cmd_ready(cmd_ready),
    .data_valid(data_valid), .data_ready(data_ready),
    .load_ena(load_ena), .load_param(load_param), .load_done(load_done),
    .mac_start(mac_start), .mac_done(mac_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .weights_valid(weights_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_data_ready"}, data_ready, 0);
    chk({tag, "_load_ena"}, load_ena, 0);
    chk({tag, "_load_param"}, load_param, 0);
    chk({tag, "_mac_start"}, mac_start, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sel"}, out_sel, 0);
    chk({tag, "_wv"}, weights_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // One LOAD transaction. drop_beat (>=1) removes data_valid on that beat,
  // abort_beat issues ABORT on that beat, give_done controls load_done on
  // the last beat. -1 disables the drop/abort.
  task automatic do_load(input logic [6:0] p, input int drop_beat,
                         input bit give_done, input int abort_beat);
    int b = 2 * (int'(p[2:0]) + 1);
    bit ended = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_param = p;
    tick;
    cmd_valid = 1'b0; cmd_op = 2'b00;
    m_wv = 1'b0; m_err = 2'b00;
    chk("ld_busy", busy, 1);
    chk("ld_cmd_ready", cmd_ready, 0);
    chk("ld_param", load_param, p);
    chk("ld_wv_clr", weights_valid, 0);
    chk("ld_err_clr", err, 0);
    repeat ($urandom_range(0, 3)) begin
      chk("ld_wait_ena", load_ena, 0);
      chk("ld_wait_rdy", data_ready, 0);
      tick;
    end
    data_valid = 1'b1;
    tick;
    for (int k = 0; k < b && !ended; k++) begin
      chk("ld_beat_ena", load_ena, 1);
      chk("ld_beat_rdy", data_ready, 1);
      data_valid = (k == drop_beat) ? 1'b0 : 1'b1;
      load_done  = (k == b - 1) && give_done;
      if (k == abort_beat) begin
        cmd_valid = 1'b1; cmd_op = 2'b11;
      end
      tick;
      data_valid = 1'b0; load_done = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
      if (k == abort_beat) begin
        ended = 1'b1;
        m_wv  = 1'b0;
      end else if (k == drop_beat || (k == b - 1 && !give_done)) begin
        ended = 1'b1;
        m_wv  = 1'b0;
        m_err = 2'b01;
      end
    end
    if (ended) begin
      chk("ld_end_ena", load_ena, 0);
      chk("ld_end_busy", busy, 0);
      chk("ld_end_wv", weights_valid, m_wv);
      chk("ld_end_err", err, m_err);
    end else begin
      chk("settle_ena", load_ena, 0);
      chk("settle_busy", busy, 1);
      chk("settle_wv", weights_valid, 0);
      tick;
      m_wv = 1'b1;
      chk("ld_wv_set", weights_valid, 1);
      chk("ld_done_busy", busy, 0);
      chk("ld_done_err", err, 0);
    end
  endtask

  // One RUN transaction. mac_delay (>=1) is the cycle distance from mac_start
  // to mac_done; rdy_pat bit i drives out_ready on drain cycle i; abort_sel
  // issues ABORT when that index is presented (-1 disables).
  task automatic do_run(input logic [6:0] p, input int mac_delay,
                        input logic [15:0] rdy_pat, input int abort_sel);
    int n = int'(p[2:0]) + 1;
    int sel = 0;
    int i = 0;
    bit done = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_param = p;
    tick;
    cmd_valid = 1'b0; cmd_op = 2'b00;
    chk("run_param", load_param, p);
    if (!m_wv) begin
      m_err = 2'b10;
      repeat (3) begin
        chk("nowv_busy", busy, 0);
        chk("nowv_err", err, m_err);
        chk("nowv_mac", mac_start, 0);
        tick;
      end
      return;
    end
    m_err = 2'b00;
    chk("run_busy", busy, 1);
    chk("run_err", err, 0);
    repeat ($urandom_range(0, 2)) begin
      chk("rin_mac_idle", mac_start, 0);
      chk("rin_rdy_idle", data_ready, 0);
      tick;
    end
    data_valid = 1'b1;
    tick;
    data_valid = 1'b0;
    chk("mac_start", mac_start, 1);
    chk("rin_accept", data_ready, 1);
    tick;
    chk("mac_pulse", mac_start, 0);
    repeat (mac_delay - 1) begin
      chk("comp_ov", out_valid, 0);
      cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 2'b01; cmd_param = ~p;
      tick;
    end
    cmd_valid = 1'b0; cmd_op = 2'b00;
    mac_done = 1'b1;
    tick;
    mac_done = 1'b0;
    chk("drain_ov0", out_valid, 1);
    chk("drain_sel0", out_sel, 0);
    chk("run_param_hold", load_param, p);
    while (!done && i < 40) begin
      if (sel == abort_sel) begin
        cmd_valid = 1'b1; cmd_op = 2'b11;
        tick;
        cmd_valid = 1'b0; cmd_op = 2'b00;
        done = 1'b1;
        chk("abort_ov", out_valid, 0);
        chk("abort_sel", out_sel, 0);
        chk("abort_busy", busy, 0);
        chk("abort_wv", weights_valid, m_wv);
        chk("abort_err", err, m_err);
      end else begin
        out_ready = (i < 16) ? rdy_pat[i] : 1'b1;
        tick;
        if (out_ready) begin
          if (sel == n - 1) begin
            done = 1'b1;
            chk("drain_end_ov", out_valid, 0);
            chk("drain_end_busy", busy, 0);
            chk("drain_end_sel", out_sel, 0);
            chk("drain_end_wv", weights_valid, m_wv);
          end else begin
            sel++;
          end
        end
        out_ready = 1'b0;
        if (!done) begin
          chk("drain_ov", out_valid, 1);
          chk("drain_sel", out_sel, sel);
        end
      end
      i++;
    end
    chk("drain_timeout", done, 1);
  endtask

  initial begin
    logic [6:0] rp;
    int bb;
    int mode;

    rst_n = 1'b0;
    tick;
    tick;
    check_reset("rst");
    rst_n = 1'b1;
    tick;
    check_reset("post_rst");

    // RUN before any weights were loaded.
    do_run(7'b0001_011, 5, 16'hFFFF, -1);
    // Clean 8-beat load, then one with a gap on beat 3.
    do_load(7'b0001_011, -1, 1'b1, -1);
    do_load(7'b0001_011, 3, 1'b1, -1);
    // Good load, then RUN with the 1,0,1,1,1 ready pattern.
    do_load(7'b0001_011, -1, 1'b1, -1);
    do_run(7'b0001_011, 5, 16'b0000_0000_0001_1101, -1);
    // ABORT in drain at index 2, then a normal RUN.
    do_run(7'b0001_011, 3, 16'hFFFF, 2);
    do_run(7'b0001_011, 2, 16'($urandom), -1);
    // ABORT at beat 4 of a load, then a full 16-beat load.
    do_load(7'b0001_011, -1, 1'b1, 4);
    do_load(7'b0000_111, -1, 1'b1, -1);
    do_run(7'b0000_111, 1, 16'hFFFF, -1);
    // Missing load_done, and ABORT coinciding with the last beat.
    do_load(7'b0101_001, -1, 1'b0, -1);
    do_load(7'b0101_001, -1, 1'b1, 3);

    // Reset in the middle of a burst.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_param = 7'h2b;
    tick;
    cmd_valid = 1'b0; cmd_op = 2'b00; data_valid = 1'b1;
    tick;
    tick;
    tick;
    chk("mid_ena", load_ena, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; data_valid = 1'b0;
    check_reset("mid_rst");
    m_wv = 1'b0; m_err = 2'b00;

    // Randomized transactions.
    for (int it = 0; it < 30; it++) begin
      rp = 7'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        bb   = 2 * (int'(rp[2:0]) + 1);
        mode = int'($urandom_range(0, 5));
        do_load(rp,
                (mode == 1) ? int'($urandom_range(1, bb - 1)) : -1,
                mode != 2,
                (mode == 3) ? int'($urandom_range(0, bb - 1)) : -1);
      end else begin
        do_run(rp, int'($urandom_range(1, 6)), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rp[2:0]))) : -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
